// File: rtl/addsub_seq_ctrl_if.sv
// addsub_seq_ctrl_if: request/result bundle for the add/subtract sequencer.
// The master side issues start with operands and the sub/add select. The slave side
// returns busy, the one-cycle done pulse and the result.
// The optional borrow wire is present only when ADDSUB_BORROW_FLAG_EN is defined.
interface addsub_seq_ctrl_if #(
   parameter int unsigned OP_W  = 1027,
   parameter int unsigned RES_W = 1028
);

   logic             start;
   logic             subtract;
   logic [OP_W-1:0]  in_a;
   logic [OP_W-1:0]  in_b;
   logic             busy;
   logic             done;
   logic [RES_W-1:0] result;
`ifdef ADDSUB_BORROW_FLAG_EN
   logic             borrow;
`endif

`ifdef ADDSUB_BORROW_FLAG_EN
   modport master (
      output start, subtract, in_a, in_b,
      input  busy, done, result, borrow
   );

   modport slave (
      input  start, subtract, in_a, in_b,
      output busy, done, result, borrow
   );
`else
   modport master (
      output start, subtract, in_a, in_b,
      input  busy, done, result
   );

   modport slave (
      input  start, subtract, in_a, in_b,
      output busy, done, result
   );
`endif

endinterface

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: multi-cycle add/subtract sequencer for wide Montgomery/RSA operands.
// One adder_514 instance is stepped over CHUNK_W-bit slices, starting with the LSB slice.
// A register carries the carry from one slice to the next.
// Subtraction is A + ~B + 1. The +1 enters as carry-in on slice 0.
// Optional feature: define ADDSUB_BORROW_FLAG_EN to add the borrow output. The flag is
// A<B on a subtract and 0 on an add.

// Shared slice adder: {cout, sum} = a + b + cin.
module adder_514 (
   input  logic [513:0] a,
   input  logic [513:0] b,
   input  logic         cin,
   output logic [513:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {514'd0, cin};

endmodule

module addsub_seq_ctrl #(
   parameter int unsigned OP_W    = 1027,
   parameter int unsigned CHUNK_W = 514
) (
   input logic              clk,
   input logic              resetn,   // synchronous, active-high
   addsub_seq_ctrl_if.slave bus
);

   localparam int unsigned AdderW     = 514;
   localparam int unsigned NUM_CHUNKS = (OP_W + CHUNK_W - 1) / CHUNK_W;
   localparam int unsigned RES_W      = NUM_CHUNKS * CHUNK_W;
   localparam int unsigned KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [KW-1:0] KLast    = KW'(NUM_CHUNKS - 1);

   // The slice width is tied to the single hard adder instance.
   if (CHUNK_W != AdderW) begin : g_chunk_check
      $error("addsub_seq_ctrl: CHUNK_W must equal the adder_514 width (514)");
   end

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               accept;
   logic               last_slice;

   logic [KW-1:0]      k_q;
   logic               carry_q;
   logic [RES_W-1:0]   a_q;
   logic [RES_W-1:0]   b_q;
   logic               sub_q;
   logic [RES_W-1:0]   result_q;
`ifdef ADDSUB_BORROW_FLAG_EN
   logic               borrow_q;
`endif

   logic [CHUNK_W-1:0] slice_a;
   logic [CHUNK_W-1:0] slice_b;
   logic [CHUNK_W-1:0] slice_sum;
   logic               slice_cin;
   logic               slice_cout;

   assign last_slice = (k_q == KLast);

   // Present the current slice to the adder. Subtract inverts B and injects +1 on slice 0.
   always_comb begin
      slice_a   = a_q[k_q*CHUNK_W +: CHUNK_W];
      slice_b   = b_q[k_q*CHUNK_W +: CHUNK_W] ^ {CHUNK_W{sub_q}};
      slice_cin = (k_q == '0) ? sub_q : carry_q;
   end

   adder_514 u_adder (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (slice_cin),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A start in RUN is ignored. A start in DONE is taken back-to-back.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (last_slice) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath: capture operands on accept, then write one result slice per RUN cycle.
   // result is deliberately not cleared on accept, so the previous value stays visible.
   always_ff @(posedge clk) begin
      if (resetn) begin
         k_q      <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         result_q <= '0;
`ifdef ADDSUB_BORROW_FLAG_EN
         borrow_q <= 1'b0;
`endif
      end else if (accept) begin
         a_q   <= RES_W'(bus.in_a);
         b_q   <= RES_W'(bus.in_b);
         sub_q <= bus.subtract;
         k_q   <= '0;
      end else if (state_q == StRun) begin
         result_q[k_q*CHUNK_W +: CHUNK_W] <= slice_sum;
         carry_q                          <= slice_cout;
         k_q                              <= last_slice ? '0 : k_q + 1'b1;
`ifdef ADDSUB_BORROW_FLAG_EN
         // No carry out of the top slice on A + ~B + 1 means A < B.
         if (last_slice) begin
            borrow_q <= sub_q & ~slice_cout;
         end
`endif
      end
   end

   assign bus.busy   = (state_q == StRun);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;
`ifdef ADDSUB_BORROW_FLAG_EN
   assign bus.borrow = borrow_q;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb_addsub_seq_ctrl: table vectors, hand-written timing sequences and random operations.
// Random operations are checked against a plain-arithmetic reference model.
module tb_addsub_seq_ctrl;

   localparam int unsigned OP_W    = 1027;
   localparam int unsigned CHUNK_W = 514;
   localparam int unsigned RES_W   = 1028;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   addsub_seq_ctrl_if #(.OP_W(OP_W), .RES_W(RES_W)) bus ();

   addsub_seq_ctrl #(
      .OP_W    (OP_W),
      .CHUNK_W (CHUNK_W)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   typedef struct {
      string            name;
      logic             sub;
      logic [OP_W-1:0]  a;
      logic [OP_W-1:0]  b;
      logic [RES_W-1:0] exp_res;
      logic             exp_borrow;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [RES_W-1:0] act,
                      input logic [RES_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
                  act[RES_W-1:RES_W-32], act[63:0], exp[RES_W-1:RES_W-32], exp[63:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic sub, input logic [OP_W-1:0] a,
                              input logic [OP_W-1:0] b);
      bus.subtract = sub;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.start    = 1'b1;
   endtask

   // Issue one op, check busy/done timing and the result, then one idle cycle for the done pulse.
   task automatic run_op(input string name, input logic sub, input logic [OP_W-1:0] a,
                         input logic [OP_W-1:0] b, input logic [RES_W-1:0] exp_res,
                         input logic exp_borrow);
      drive_start(sub, a, b);
      step();
      bus.start = 1'b0;
      chk({name, " busy T+1"}, RES_W'(bus.busy), RES_W'(1));
      chk({name, " done T+1"}, RES_W'(bus.done), RES_W'(0));
      step();
      chk({name, " busy T+2"}, RES_W'(bus.busy), RES_W'(1));
      chk({name, " done T+2"}, RES_W'(bus.done), RES_W'(0));
      step();
      chk({name, " busy T+3"}, RES_W'(bus.busy), RES_W'(0));
      chk({name, " done T+3"}, RES_W'(bus.done), RES_W'(1));
      chk({name, " result"}, bus.result, exp_res);
`ifdef ADDSUB_BORROW_FLAG_EN
      chk({name, " borrow"}, RES_W'(bus.borrow), RES_W'(exp_borrow));
`else
      if (exp_borrow === 1'bx) $display("note: unknown borrow expectation");
`endif
      step();
      chk({name, " done T+4"}, RES_W'(bus.done), RES_W'(0));
      chk({name, " result held"}, bus.result, exp_res);
   endtask

   function automatic logic [RES_W-1:0] model_res(input logic sub, input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
      logic [RES_W-1:0] ea = RES_W'(a);
      logic [RES_W-1:0] eb = RES_W'(b);
      return sub ? (ea - eb) : (ea + eb);
   endfunction

   function automatic logic [OP_W-1:0] rand_operand();
      logic [OP_W-1:0] v = '0;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = '1;
         2: v = OP_W'(1) << $urandom_range(0, OP_W - 1);
         default: begin
            for (int i = 0; i < (OP_W + 31) / 32; i++) v = (v << 32) | OP_W'($urandom);
         end
      endcase
      return v;
   endfunction

   vec_t vecs[9];
   logic [OP_W-1:0]  ones_op;
   logic [RES_W-1:0] ones_res;

   initial begin
      ones_op  = '1;
      ones_res = '1;
      vecs[0] = '{"add 1+max", 1'b0, OP_W'(1), ones_op, RES_W'(1) << 1027, 1'b0};
      vecs[1] = '{"add slice carry", 1'b0, (OP_W'(1) << 514) - OP_W'(1), OP_W'(1),
                  RES_W'(1) << 514, 1'b0};
      vecs[2] = '{"sub 5-3", 1'b1, OP_W'(5), OP_W'(3), RES_W'(2), 1'b0};
      vecs[3] = '{"sub 3-5", 1'b1, OP_W'(3), OP_W'(5), ones_res - RES_W'(1), 1'b1};
      vecs[4] = '{"add max+max", 1'b0, ones_op, ones_op, ones_res - RES_W'(1), 1'b0};
      vecs[5] = '{"sub 0-0", 1'b1, OP_W'(0), OP_W'(0), RES_W'(0), 1'b0};
      vecs[6] = '{"sub a==b", 1'b1, OP_W'(1) << 1026, OP_W'(1) << 1026, RES_W'(0), 1'b0};
      vecs[7] = '{"sub 0-1", 1'b1, OP_W'(0), OP_W'(1), ones_res, 1'b1};
      vecs[8] = '{"sub max-0", 1'b1, ones_op, OP_W'(0), {1'b0, ones_op}, 1'b0};

      bus.start    = 1'b0;
      bus.subtract = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      resetn       = 1'b1;
      step();
      step();
      resetn = 1'b0;
      chk("reset busy", RES_W'(bus.busy), RES_W'(0));
      chk("reset done", RES_W'(bus.done), RES_W'(0));
      chk("reset result", bus.result, RES_W'(0));
`ifdef ADDSUB_BORROW_FLAG_EN
      chk("reset borrow", RES_W'(bus.borrow), RES_W'(0));
`endif
      step();

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].exp_res,
                vecs[i].exp_borrow);
      end

      // Start during RUN is ignored; operands are not re-sampled.
      drive_start(1'b0, OP_W'(1), ones_op);
      step();
      drive_start(1'b1, OP_W'(7), OP_W'(7));
      chk("ignore busy T+1", RES_W'(bus.busy), RES_W'(1));
      step();
      bus.start = 1'b0;
      chk("ignore done T+2", RES_W'(bus.done), RES_W'(0));
      step();
      chk("ignore done T+3", RES_W'(bus.done), RES_W'(1));
      chk("ignore result", bus.result, RES_W'(1) << 1027);
      step();
      chk("ignore no 2nd op", RES_W'(bus.busy), RES_W'(0));
      chk("ignore done T+4", RES_W'(bus.done), RES_W'(0));

      // Reset mid-RUN aborts without a done pulse.
      drive_start(1'b0, ones_op, OP_W'(1));
      step();
      bus.start = 1'b0;
      resetn    = 1'b1;
      step();
      resetn = 1'b0;
      chk("abort busy", RES_W'(bus.busy), RES_W'(0));
      chk("abort done", RES_W'(bus.done), RES_W'(0));
      chk("abort result", bus.result, RES_W'(0));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort no done", RES_W'(bus.done), RES_W'(0));
      end
      run_op("after abort", 1'b0, OP_W'(10), OP_W'(20), RES_W'(30), 1'b0);

      // Back-to-back start in the done cycle.
      drive_start(1'b0, OP_W'(5), OP_W'(3));
      step();
      bus.start = 1'b0;
      step();
      step();
      chk("b2b first done", RES_W'(bus.done), RES_W'(1));
      chk("b2b first result", bus.result, RES_W'(8));
      drive_start(1'b1, OP_W'(1) << 1026, OP_W'(1) << 1026);
      step();
      bus.start = 1'b0;
      chk("b2b busy T+4", RES_W'(bus.busy), RES_W'(1));
      chk("b2b done T+4", RES_W'(bus.done), RES_W'(0));
      step();
      chk("b2b done T+5", RES_W'(bus.done), RES_W'(0));
      step();
      chk("b2b done T+6", RES_W'(bus.done), RES_W'(1));
      chk("b2b result", bus.result, RES_W'(0));
      step();

      // Random operations against the reference model.
      for (int n = 0; n < 40; n++) begin
         logic            sub;
         logic [OP_W-1:0] a;
         logic [OP_W-1:0] b;
         sub = 1'($urandom);
         a   = rand_operand();
         b   = ($urandom_range(0, 7) == 0) ? a : rand_operand();
         run_op($sformatf("rand %0d", n), sub, a, b, model_res(sub, a, b), sub && (a < b));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
